// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: register-address/control inputs from D/E/M/W and stall/flush/forward outputs.
// The master drives the pipeline view; the slave (the controller) drives the control lines.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] RA1_D;
  logic [REG_ADDR_W-1:0] RA2_D;
  logic [REG_ADDR_W-1:0] RA1_E;
  logic [REG_ADDR_W-1:0] RA2_E;
  logic [REG_ADDR_W-1:0] WRITE_REG_E;
  logic [REG_ADDR_W-1:0] WRITE_REG_M;
  logic [REG_ADDR_W-1:0] WRITE_REG_W;
  logic                  REG_WRITE_E;
  logic                  REG_WRITE_M;
  logic                  REG_WRITE_W;
  logic                  MEM_TO_REG_E;
  logic                  BRANCH_TAKEN_E;
  logic                  MC_START_E;
  logic [LAT_W-1:0]      MC_LAT_E;

  logic                  STALL_F;
  logic                  STALL_D;
  logic                  STALL_E;
  logic                  FLUSH_D;
  logic                  FLUSH_E;
  logic                  FLUSH_M;
  logic [1:0]            FORWARD_A_E;
  logic [1:0]            FORWARD_B_E;
  logic                  BUSY;
  logic [CNT_W-1:0]      STALL_CNT;

  modport master (
    output RA1_D, RA2_D, RA1_E, RA2_E, WRITE_REG_E, WRITE_REG_M, WRITE_REG_W,
    output REG_WRITE_E, REG_WRITE_M, REG_WRITE_W, MEM_TO_REG_E, BRANCH_TAKEN_E,
    output MC_START_E, MC_LAT_E,
    input  STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E, FLUSH_M,
    input  FORWARD_A_E, FORWARD_B_E, BUSY, STALL_CNT
  );

  modport slave (
    input  RA1_D, RA2_D, RA1_E, RA2_E, WRITE_REG_E, WRITE_REG_M, WRITE_REG_W,
    input  REG_WRITE_E, REG_WRITE_M, REG_WRITE_W, MEM_TO_REG_E, BRANCH_TAKEN_E,
    input  MC_START_E, MC_LAT_E,
    output STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E, FLUSH_M,
    output FORWARD_A_E, FORWARD_B_E, BUSY, STALL_CNT
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use stall, branch flush, multi-cycle E sequencing.
// Control outputs are combinational (0 cycles); a multi-cycle op of latency N holds F/D/E for N-1 cycles.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  hazard_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    MC_LAST = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LAT_W-1:0]   r_cnt;
  logic [LAT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_lu;
  logic               w_mc_go;
  logic               w_stall_f;
  logic               w_stall_d;
  logic               w_stall_e;
  logic               w_flush_d;
  logic               w_flush_e;
  logic               w_flush_m;
  logic [1:0]         w_fwd_a;
  logic [1:0]         w_fwd_b;

  // M result is younger than W, so it wins when both target the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] ra,
    input logic                  rw_m,
    input logic [REG_ADDR_W-1:0] wr_m,
    input logic                  rw_w,
    input logic [REG_ADDR_W-1:0] wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rw_m && (wr_m != '0) && (wr_m == ra)) begin
      sel = 2'b10;
    end else if (rw_w && (wr_w != '0) && (wr_w == ra)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_lu = bus.MEM_TO_REG_E && bus.REG_WRITE_E && (bus.WRITE_REG_E != '0) &&
                ((bus.WRITE_REG_E == bus.RA1_D) || (bus.WRITE_REG_E == bus.RA2_D));

  // Latencies 0 and 1 complete in a single E cycle and need no sequencing.
  assign w_mc_go = bus.MC_START_E && (bus.MC_LAT_E >= LAT_W'(2));

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!CLR) begin
      w_fwd_a = fwd_sel(bus.RA1_E, bus.REG_WRITE_M, bus.WRITE_REG_M, bus.REG_WRITE_W, bus.WRITE_REG_W);
      w_fwd_b = fwd_sel(bus.RA2_E, bus.REG_WRITE_M, bus.WRITE_REG_M, bus.REG_WRITE_W, bus.WRITE_REG_W);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall_f   = 1'b0;
    w_stall_d   = 1'b0;
    w_stall_e   = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_flush_m   = 1'b0;

    if (CLR) begin
      w_flush_d   = 1'b1;
      w_flush_e   = 1'b1;
      w_flush_m   = 1'b1;
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mc_go) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_flush_m = 1'b1;
            if (bus.MC_LAT_E == LAT_W'(2)) begin
              w_state_nxt = MC_LAST;
            end else begin
              w_cnt_nxt   = bus.MC_LAT_E - LAT_W'(2);
              w_state_nxt = MC_WAIT;
            end
          end else if (bus.BRANCH_TAKEN_E) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
          end else if (w_lu) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
          end
        end

        MC_WAIT: begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_flush_m = 1'b1;
          w_cnt_nxt = r_cnt - LAT_W'(1);
          if (r_cnt <= LAT_W'(1)) begin
            w_state_nxt = MC_LAST;
          end
        end

        MC_LAST: begin
          // The op is still presented on MC_START_E here; it must not restart.
          w_state_nxt = RUN;
          if (bus.BRANCH_TAKEN_E) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
          end else if (w_lu) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
          end
        end

        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_stall_cnt <= '0;
    end else if (w_stall_d && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.STALL_F     = w_stall_f;
  assign bus.STALL_D     = w_stall_d;
  assign bus.STALL_E     = w_stall_e;
  assign bus.FLUSH_D     = w_flush_d;
  assign bus.FLUSH_E     = w_flush_e;
  assign bus.FLUSH_M     = w_flush_m;
  assign bus.FORWARD_A_E = w_fwd_a;
  assign bus.FORWARD_B_E = w_fwd_b;
  assign bus.BUSY        = (r_state != RUN);
  assign bus.STALL_CNT   = r_stall_cnt;

  a_stall_e_holds_d: assert property (@(posedge CLK) disable iff (CLR) w_stall_e |-> w_stall_d);
  a_wait_cnt_live:   assert property (@(posedge CLK) disable iff (CLR) (r_state == MC_WAIT) |-> (r_cnt != '0));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against an occupancy-based model.
module tb_hazard_ctrl;
  localparam int RW = 5;
  localparam int LW = 3;
  localparam int CW = 16;

  logic CLK = 1'b0;
  logic CLR;
  int   vectors = 0;
  int   miscompares = 0;
  int   occ_left = 0;   // cycles the current multi-cycle op still occupies E (0 = none)
  int   scnt = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.REG_ADDR_W(RW), .LAT_W(LW), .CNT_W(CW)) hif ();

  hazard_ctrl #(.REG_ADDR_W(RW), .LAT_W(LW), .CNT_W(CW)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (hif.slave)
  );

  // Output vector layout: {SF,SD,SE,FD,FE,FM,FA[1:0],FB[1:0],BUSY,CNT[15:0]}
  function automatic logic [26:0] dut_out();
    return {hif.STALL_F, hif.STALL_D, hif.STALL_E, hif.FLUSH_D, hif.FLUSH_E, hif.FLUSH_M,
            hif.FORWARD_A_E, hif.FORWARD_B_E, hif.BUSY, hif.STALL_CNT};
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] ra);
    if (ra == 0) return 2'd0;
    if (hif.REG_WRITE_M && hif.WRITE_REG_M == ra) return 2'd2;
    if (hif.REG_WRITE_W && hif.WRITE_REG_W == ra) return 2'd1;
    return 2'd0;
  endfunction

  function automatic int occ_now();
    if (occ_left == 0 && hif.MC_START_E && hif.MC_LAT_E >= 2) return int'(hif.MC_LAT_E);
    return occ_left;
  endfunction

  function automatic logic [26:0] model_out();
    logic sf, sd, se, fd, fe, fm, lu, busy;
    logic [1:0] fa, fb;
    int occ;
    {sf, sd, se, fd, fe, fm} = 6'b0;
    fa = 2'd0;
    fb = 2'd0;
    busy = (occ_left != 0);
    lu = hif.MEM_TO_REG_E && hif.REG_WRITE_E && hif.WRITE_REG_E != 0 &&
         (hif.WRITE_REG_E == hif.RA1_D || hif.WRITE_REG_E == hif.RA2_D);
    if (CLR) begin
      {fd, fe, fm} = 3'b111;
    end else begin
      fa = ref_fwd(hif.RA1_E);
      fb = ref_fwd(hif.RA2_E);
      occ = occ_now();
      if (occ >= 2) begin
        {sf, sd, se, fm} = 4'b1111;
      end else if (hif.BRANCH_TAKEN_E) begin
        {fd, fe} = 2'b11;
      end else if (lu) begin
        {sf, sd, fe} = 3'b111;
      end
    end
    return {sf, sd, se, fd, fe, fm, fa, fb, busy, 16'(scnt)};
  endfunction

  task automatic tick();
    logic [26:0] e;
    int occ;
    e = model_out();
    occ = occ_now();
    @(posedge CLK);
    if (CLR) begin
      occ_left = 0;
      scnt = 0;
    end else begin
      occ_left = (occ > 0) ? occ - 1 : 0;
      if (e[25] && scnt < 65535) scnt = scnt + 1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    hif.RA1_D = '0; hif.RA2_D = '0; hif.RA1_E = '0; hif.RA2_E = '0;
    hif.WRITE_REG_E = '0; hif.WRITE_REG_M = '0; hif.WRITE_REG_W = '0;
    hif.REG_WRITE_E = 1'b0; hif.REG_WRITE_M = 1'b0; hif.REG_WRITE_W = 1'b0;
    hif.MEM_TO_REG_E = 1'b0; hif.BRANCH_TAKEN_E = 1'b0;
    hif.MC_START_E = 1'b0; hif.MC_LAT_E = '0;
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    hif.REG_WRITE_M = 1'b1; hif.WRITE_REG_M = 5'd4; hif.RA1_E = 5'd4;
    CLR = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    vectors++;
    if (dut_out() !== {3'b000, 3'b111, 2'b00, 2'b00, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", dut_out(), {3'b000, 3'b111, 4'b0, 1'b0, 16'h0});
    end
    tick();
    CLR = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    hif.REG_WRITE_M = 1'b1; hif.WRITE_REG_M = 5'd5;
    hif.REG_WRITE_W = 1'b1; hif.WRITE_REG_W = 5'd5;
    hif.RA1_E = 5'd5; hif.RA2_E = 5'd0;
    @(negedge CLK);
    vectors++;
    if (hif.FORWARD_A_E !== 2'b10 || hif.FORWARD_B_E !== 2'b00) begin
      miscompares++;
      $display("FAIL fwd_m_priority: got A=%b B=%b want A=10 B=00", hif.FORWARD_A_E, hif.FORWARD_B_E);
    end
    tick();
    hif.REG_WRITE_M = 1'b0;
    @(negedge CLK);
    vectors++;
    if (hif.FORWARD_A_E !== 2'b01) begin
      miscompares++;
      $display("FAIL fwd_w_only: got %b want 01", hif.FORWARD_A_E);
    end
    tick();
    hif.REG_WRITE_M = 1'b1; hif.WRITE_REG_M = 5'd9; hif.RA2_E = 5'd9;
    hif.WRITE_REG_W = 5'd0; hif.RA1_E = 5'd0;
    @(negedge CLK);
    vectors++;
    if (hif.FORWARD_A_E !== 2'b00 || hif.FORWARD_B_E !== 2'b10) begin
      miscompares++;
      $display("FAIL fwd_r0_and_b: got A=%b B=%b want A=00 B=10", hif.FORWARD_A_E, hif.FORWARD_B_E);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    hif.MEM_TO_REG_E = 1'b1; hif.REG_WRITE_E = 1'b1; hif.WRITE_REG_E = 5'd7; hif.RA2_D = 5'd7;
    @(negedge CLK);
    vectors++;
    if ({hif.STALL_F, hif.STALL_D, hif.STALL_E, hif.FLUSH_E, hif.STALL_CNT} !== {3'b110, 1'b1, 16'd0}) begin
      miscompares++;
      $display("FAIL lu_stall: got SF/SD/SE/FE=%b%b%b%b cnt=%0d want 1101 cnt=0",
               hif.STALL_F, hif.STALL_D, hif.STALL_E, hif.FLUSH_E, hif.STALL_CNT);
    end
    tick();
    clear_inputs();
    @(negedge CLK);
    vectors++;
    if (hif.STALL_D !== 1'b0 || hif.STALL_CNT !== 16'd1) begin
      miscompares++;
      $display("FAIL lu_one_cycle: got SD=%b cnt=%0d want SD=0 cnt=1", hif.STALL_D, hif.STALL_CNT);
    end
    tick();
    hif.MEM_TO_REG_E = 1'b1; hif.REG_WRITE_E = 1'b1; hif.WRITE_REG_E = 5'd0; hif.RA1_D = 5'd0;
    @(negedge CLK);
    vectors++;
    if (hif.STALL_D !== 1'b0 || hif.FLUSH_E !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_r0: got SD=%b FE=%b want 0 0", hif.STALL_D, hif.FLUSH_E);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_multicycle(input int n);
    int cycles;
    logic exp_se, exp_busy;
    do_reset();
    cycles = (n < 2) ? 2 : n;
    hif.MC_START_E = 1'b1;
    hif.MC_LAT_E = LW'(n);
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      exp_se = (n >= 2) && (c < n - 1);
      exp_busy = (n >= 2) && (c > 0);
      vectors++;
      if (hif.STALL_E !== exp_se || hif.BUSY !== exp_busy) begin
        miscompares++;
        $display("FAIL mc_n%0d_cyc%0d: got SE=%b BUSY=%b want SE=%b BUSY=%b",
                 n, c, hif.STALL_E, hif.BUSY, exp_se, exp_busy);
      end
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++;
        $display("FAIL mc_n%0d_model_cyc%0d: got %h want %h", n, c, dut_out(), model_out());
      end
      tick();
    end
    hif.MC_START_E = 1'b0;
    @(negedge CLK);
    vectors++;
    if (hif.BUSY !== 1'b0 || hif.STALL_CNT !== 16'((n >= 2) ? n - 1 : 0)) begin
      miscompares++;
      $display("FAIL mc_n%0d_done: got BUSY=%b cnt=%0d want BUSY=0 cnt=%0d",
               n, hif.BUSY, hif.STALL_CNT, (n >= 2) ? n - 1 : 0);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_vs_lu();
    do_reset();
    hif.MEM_TO_REG_E = 1'b1; hif.REG_WRITE_E = 1'b1; hif.WRITE_REG_E = 5'd3; hif.RA1_D = 5'd3;
    hif.BRANCH_TAKEN_E = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({hif.FLUSH_D, hif.FLUSH_E, hif.STALL_D, hif.STALL_F} !== 4'b1100) begin
      miscompares++;
      $display("FAIL br_over_lu: got FD/FE/SD/SF=%b%b%b%b want 1100",
               hif.FLUSH_D, hif.FLUSH_E, hif.STALL_D, hif.STALL_F);
    end
    tick();
    clear_inputs();
    hif.MC_START_E = 1'b1; hif.MC_LAT_E = 3'd5;
    tick();
    hif.BRANCH_TAKEN_E = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({hif.FLUSH_D, hif.FLUSH_E, hif.STALL_D, hif.BUSY} !== 4'b0011) begin
      miscompares++;
      $display("FAIL br_in_wait: got FD/FE/SD/BUSY=%b%b%b%b want 0011",
               hif.FLUSH_D, hif.FLUSH_E, hif.STALL_D, hif.BUSY);
    end
    for (int i = 0; i < 4; i++) tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    hif.MC_START_E = 1'b1; hif.MC_LAT_E = 3'd7;
    tick();
    tick();
    CLR = 1'b1;
    hif.REG_WRITE_M = 1'b1; hif.WRITE_REG_M = 5'd6; hif.RA1_E = 5'd6;
    @(negedge CLK);
    vectors++;
    if ({hif.STALL_F, hif.STALL_D, hif.STALL_E, hif.FLUSH_D, hif.FLUSH_E, hif.FLUSH_M,
         hif.FORWARD_A_E} !== 8'b000_111_00) begin
      miscompares++;
      $display("FAIL clr_mid_op: got SF/SD/SE=%b%b%b FD/FE/FM=%b%b%b FA=%b want 000 111 00",
               hif.STALL_F, hif.STALL_D, hif.STALL_E, hif.FLUSH_D, hif.FLUSH_E, hif.FLUSH_M, hif.FORWARD_A_E);
    end
    tick();
    CLR = 1'b0;
    clear_inputs();
    @(negedge CLK);
    vectors++;
    if (hif.BUSY !== 1'b0 || hif.STALL_CNT !== 16'd0 || hif.STALL_E !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_after: got BUSY=%b cnt=%0d SE=%b want 0 0 0", hif.BUSY, hif.STALL_CNT, hif.STALL_E);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      CLR = ($urandom_range(0, 99) == 0);
      hif.RA1_D = RW'($urandom_range(0, 3)); hif.RA2_D = RW'($urandom_range(0, 3));
      hif.RA1_E = RW'($urandom_range(0, 3)); hif.RA2_E = RW'($urandom_range(0, 3));
      hif.WRITE_REG_E = RW'($urandom_range(0, 3));
      hif.WRITE_REG_M = RW'($urandom_range(0, 3));
      hif.WRITE_REG_W = RW'($urandom_range(0, 3));
      hif.REG_WRITE_E = 1'($urandom); hif.REG_WRITE_M = 1'($urandom); hif.REG_WRITE_W = 1'($urandom);
      hif.MEM_TO_REG_E = 1'($urandom);
      hif.BRANCH_TAKEN_E = ($urandom_range(0, 3) == 0);
      hif.MC_START_E = ($urandom_range(0, 5) == 0);
      hif.MC_LAT_E = LW'($urandom_range(0, 7));
      @(negedge CLK);
      vectors++;
      if (dut_out() !== model_out()) begin
        miscompares++;
        $display("FAIL random_%0d: got %h want %h", i, dut_out(), model_out());
      end
      tick();
    end
    CLR = 1'b0;
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    hif.MEM_TO_REG_E = 1'b1; hif.REG_WRITE_E = 1'b1; hif.WRITE_REG_E = 5'd2; hif.RA1_D = 5'd2;
    for (int i = 0; i < 65534; i++) tick();
    @(negedge CLK);
    vectors++;
    if (hif.STALL_CNT !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL sat_pre: got %h want fffe", hif.STALL_CNT);
    end
    tick();
    @(negedge CLK);
    vectors++;
    if (hif.STALL_CNT !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_reach: got %h want ffff", hif.STALL_CNT);
    end
    for (int i = 0; i < 4; i++) tick();
    @(negedge CLK);
    vectors++;
    if (hif.STALL_CNT !== 16'hFFFF || hif.STALL_D !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_hold: got cnt=%h SD=%b want ffff 1", hif.STALL_CNT, hif.STALL_D);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    CLR = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle(4);
    test_multicycle(2);
    test_multicycle(1);
    test_multicycle(7);
    test_branch_vs_lu();
    test_reset_mid_op();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
